instr_issue_queue: RTL and testbench
====================================

// Module: instr_issue_queue
// PURPOSE
//  Buffers 64-bit instructions from the host and issues them to the controller at one per cycle.
//  The controller decodes its instruction input on every clk edge, so this block drives an
//  all-zero NOP whenever nothing is being issued.
//  Sits directly upstream of the controller: host -> instr_issue_queue -> controller.
// PARAMETERS
//  DEPTH     16  queue entries; power of 2, >= 2
//  INSTR_W   64  instruction width; opcode is [INSTR_W-1 -: 5]
//  HALT_OP   5'b11111  opcode that stops issue; consumed, never forwarded
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  host_valid   in   1        host presents an instruction
//  host_instr   in   INSTR_W  instruction word
//  host_ready   out  1        queue can accept; equals ~full, from registered count
//  start        in   1        pulse: IDLE/HALTED -> RUN
//  flush        in   1        pulse: discard queued entries
//  stall        in   1        downstream busy; no pop while high
//  instruction  out  INSTR_W  registered word to controller; 0 = NOP
//  issued       out  1        1-cycle pulse, same cycle as a non-NOP instruction
//  halted       out  1        high in HALTED
//  count        out  $clog2(DEPTH)+1  occupancy
//  illegal_err  out  1        sticky flag; present only with ILLEGAL_OP_TRAP_EN
// BEHAVIOUR
//  Reset, async on rst_n low: state=IDLE; pointers, count, instruction, issued, halted and
//   illegal_err all 0; queue contents undefined. Reset mid-burst drops everything; the next
//   output is NOP.
//  Push: host_valid & host_ready at edge N writes the tail entry.
//  Pop condition: state==RUN & count>0 & ~stall & ~flush.
//  Latency: an entry pushed at edge N is popped no earlier than edge N+1. No empty bypass.
//  Pop: the head word is registered into instruction and issued=1. Any cycle without a
//   forwarded word: instruction=0, issued=0. A stall cycle outputs NOP; it does not hold the
//   previous word.
//  Simultaneous push and pop: both happen; count is unchanged. Full: host_ready=0 for that
//   cycle even if a pop occurs.
//  Pointers wrap modulo DEPTH. Count saturates at neither end, because push is blocked when
//   full and pop is blocked when empty.
//  FSM:
//   IDLE   : no pop; push allowed; start -> RUN.
//   RUN    : pop per the condition above. Popped opcode==HALT_OP -> HALTED; that cycle
//            outputs NOP with issued=0.
//   HALTED : halted=1; no pop; push allowed; start -> RUN.
//   flush in any state: count and pointers cleared at the next edge; state -> IDLE;
//            output NOP; a push in the same cycle is dropped.
//  Simultaneous start+flush: flush wins. start while in RUN: ignored.
//  Opcodes are not interpreted except HALT_OP and, with the macro below, the legality check.
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined:
//   - A popped opcode in 5'b00111..5'b11110 is replaced by NOP with issued=0.
//   - illegal_err is set sticky; only rst_n clears it.
//   - Issue continues with the next entry.
//  Undefined:
//   - illegal_err port is absent.
//   - Every non-HALT opcode is forwarded unchanged with issued=1.
// TESTING
//  T1: reset, push 3 words (op 00100), start -> 3 consecutive issued pulses carrying the words
//      in order, then instruction=0 and count=0.
//  T2: push 16 with no start -> count=16, host_ready=0; a 17th push is ignored; start -> 16
//      issues in order.
//  T3: in RUN, hold stall high for 4 cycles mid-stream -> 4 NOP cycles, no entry lost or
//      duplicated.
//  T4: queue {op 00001, HALT, op 00110}, start -> 00001 issued, halted=1, count=1;
//      start -> 00110 issued.
//  T5: 8 queued, flush together with a push -> next cycle count=0, state IDLE, output NOP.
//  T6: rst_n low mid-issue -> all outputs 0 immediately. With ILLEGAL_OP_TRAP_EN: op 01010
//      -> NOP and illegal_err=1.

Source files
------------

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: FIFO of host instructions feeding the controller at one per cycle.
// Drives an all-zero NOP whenever no word is forwarded. A popped HALT_OP opcode stops
// issue (IDLE/RUN/HALTED FSM); flush empties the queue and returns to IDLE.
// Optional feature: define ILLEGAL_OP_TRAP_EN to replace opcodes 5'b00111..5'b11110
// with NOP and raise the sticky illegal_err output.
module instr_issue_queue #(
    parameter int         DEPTH   = 16,
    parameter int         INSTR_W = 64,
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_valid,
    input  logic [INSTR_W-1:0]       host_instr,
    output logic                     host_ready,
    input  logic                     start,
    input  logic                     flush,
    input  logic                     stall,
    output logic [INSTR_W-1:0]       instruction,
    output logic                     issued,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic                     illegal_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [INSTR_W-1:0]   mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic [INSTR_W-1:0]   instr_reg;
    logic                 issued_reg;
    logic                 push, pop;
    logic [INSTR_W-1:0]   head_word;
    logic [4:0]           head_op;
    logic                 head_is_halt, head_is_illegal;

    assign head_word    = mem[rd_ptr_reg];
    assign head_op      = head_word[INSTR_W-1 -: 5];
    assign head_is_halt = (head_op == HALT_OP);

`ifdef ILLEGAL_OP_TRAP_EN
    assign head_is_illegal = (head_op >= 5'b00111) && (head_op <= 5'b11110);
`else
    assign head_is_illegal = 1'b0;
`endif

    // Full is judged from the registered count only, so a same-cycle pop never frees a slot.
    assign host_ready  = (count_reg != FULL_COUNT);
    assign push        = host_valid & host_ready & ~flush;
    assign instruction = instr_reg;
    assign issued      = issued_reg;
    assign halted      = (state_reg == HALTED);
    assign count       = count_reg;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and pop decision; flush overrides everything, including start.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                pop = (count_reg != '0) & ~stall;
                if (pop && head_is_halt) state_next = HALTED;
            end
            HALTED: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            pop        = 1'b0;
        end
    end

    // Queue storage; contents are never reset, only pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= host_instr;
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Output register: forward the popped word unless it is HALT or trapped; else NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_reg  <= '0;
            issued_reg <= 1'b0;
        end else if (pop && !head_is_halt && !head_is_illegal) begin
            instr_reg  <= head_word;
            issued_reg <= 1'b1;
        end else begin
            instr_reg  <= '0;
            issued_reg <= 1'b0;
        end
    end

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_err_reg;

    // Sticky trap flag; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_err_reg <= 1'b0;
        end else if (pop && head_is_illegal) begin
            illegal_err_reg <= 1'b1;
        end
    end

    assign illegal_err = illegal_err_reg;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Testbench for instr_issue_queue: directed scenarios plus randomized traffic, checked
// cycle by cycle against a queue-based reference model.
module tb_instr_issue_queue;

    localparam int         DEPTH   = 16;
    localparam int         INSTR_W = 64;
    localparam logic [4:0] HALT_OP = 5'b11111;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               host_valid = 1'b0;
    logic [INSTR_W-1:0] host_instr = '0;
    logic               host_ready;
    logic               start = 1'b0;
    logic               flush = 1'b0;
    logic               stall = 1'b0;
    logic [INSTR_W-1:0] instruction;
    logic               issued;
    logic               halted;
    logic [4:0]         count;
`ifdef ILLEGAL_OP_TRAP_EN
    logic               illegal_err;
`endif

    instr_issue_queue #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .HALT_OP(HALT_OP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_valid  (host_valid),
        .host_instr  (host_instr),
        .host_ready  (host_ready),
        .start       (start),
        .flush       (flush),
        .stall       (stall),
        .instruction (instruction),
        .issued      (issued),
        .halted      (halted),
        .count       (count)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .illegal_err (illegal_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [INSTR_W-1:0] q[$];
    int                 m_state = M_IDLE;
    logic [INSTR_W-1:0] exp_instr = '0;
    logic               exp_issued = 1'b0;
    logic               exp_err = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic logic [INSTR_W-1:0] mk(input logic [4:0] op, input int tag);
        return {op, 59'(tag)};
    endfunction

    function automatic logic is_illegal(input logic [4:0] op);
`ifdef ILLEGAL_OP_TRAP_EN
        return (op >= 5'd7) && (op <= 5'd30);
`else
        return (op == 5'd0) && (op != 5'd0);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".instruction"}, instruction, exp_instr);
        check({tag, ".issued"}, 64'(issued), 64'(exp_issued));
        check({tag, ".halted"}, 64'(halted), 64'(m_state == M_HALTED));
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        check({tag, ".host_ready"}, 64'(host_ready), 64'(q.size() < DEPTH));
`ifdef ILLEGAL_OP_TRAP_EN
        check({tag, ".illegal_err"}, 64'(illegal_err), 64'(exp_err));
`endif
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, compare outputs.
    task automatic step(input string tag, input logic hv, input logic [63:0] hi,
                        input logic st, input logic fl, input logic sl);
        logic [63:0] w;
        logic [4:0]  op;
        int          s0;
        logic        can_push, do_pop;
        host_valid = hv; host_instr = hi; start = st; flush = fl; stall = sl;
        @(posedge clk);
        s0       = m_state;
        can_push = hv && (q.size() < DEPTH) && !fl;
        do_pop   = (s0 == M_RUN) && (q.size() > 0) && !sl && !fl;
        exp_instr  = '0;
        exp_issued = 1'b0;
        if (do_pop) begin
            w  = q.pop_front();
            op = w[63:59];
            if (op == HALT_OP) m_state = M_HALTED;
            else if (is_illegal(op)) exp_err = 1'b1;
            else begin
                exp_instr  = w;
                exp_issued = 1'b1;
            end
        end
        if (can_push) q.push_back(hi);
        if (fl) begin
            q.delete();
            m_state = M_IDLE;
        end else if (st && s0 != M_RUN) begin
            m_state = M_RUN;
        end
        #1;
        check_outputs(tag);
        host_valid = 1'b0; start = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        q.delete();
        m_state = M_IDLE; exp_instr = '0; exp_issued = 1'b0; exp_err = 1'b0;
        check_outputs(tag);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] w;
        logic [4:0]  op;
        // Reset state
        #2;
        do_reset("reset");
        #5;

        // T1: three words then start
        for (int i = 0; i < 3; i++) step("t1_push", 1'b1, mk(5'b00100, i + 1), 1'b0, 1'b0, 1'b0);
        step("t1_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle("t1_issue", 5);

        // T2: fill to 16 in IDLE, 17th push ignored, then drain
        for (int i = 0; i < 17; i++) step("t2_fill", 1'b1, mk(5'b00010, 100 + i), 1'b0, 1'b0, 1'b0);
        step("t2_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle("t2_drain", 18);

        // T3: stall 4 cycles mid-stream while pushing continues
        for (int i = 0; i < 6; i++) step("t3_push", 1'b1, mk(5'b00011, 200 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step("t3_run", 1'b1, mk(5'b00101, 210 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("t3_stall", 1'b1, mk(5'b00101, 220 + i), 1'b0, 1'b0, 1'b1);
        idle("t3_drain", 14);

        // T4: HALT in the middle of the queue, restart with start
        step("t4_flush", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        step("t4_push", 1'b1, mk(5'b00001, 300), 1'b0, 1'b0, 1'b0);
        step("t4_push", 1'b1, mk(HALT_OP, 301), 1'b0, 1'b0, 1'b0);
        step("t4_push", 1'b1, mk(5'b00110, 302), 1'b0, 1'b0, 1'b0);
        step("t4_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle("t4_halt", 3);
        step("t4_restart", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle("t4_tail", 2);

        // T5: eight queued, flush with a simultaneous push and start
        for (int i = 0; i < 8; i++) step("t5_push", 1'b1, mk(5'b01000, 400 + i), 1'b0, 1'b0, 1'b0);
        step("t5_flush", 1'b1, mk(5'b01000, 499), 1'b1, 1'b1, 1'b0);
        idle("t5_after", 2);

        // T6: reset while issuing
        for (int i = 0; i < 6; i++) step("t6_push", 1'b1, mk(5'b00100, 500 + i), 1'b0, 1'b0, 1'b0);
        step("t6_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle("t6_issue", 2);
        do_reset("t6_reset");
        idle("t6_post", 2);
`ifdef ILLEGAL_OP_TRAP_EN
        step("t6_ill_push", 1'b1, mk(5'b01010, 600), 1'b0, 1'b0, 1'b0);
        step("t6_ill_push", 1'b1, mk(5'b00100, 601), 1'b0, 1'b0, 1'b0);
        step("t6_ill_start", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle("t6_ill_run", 3);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 11) == 0) ? HALT_OP : 5'($urandom_range(0, 31));
            w  = {op, 27'($urandom), 32'($urandom)};
            step("rand", 1'($urandom_range(0, 3) != 0), w,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
